// File: rtl/core_ex_excp_pkg.sv
// core_ex_excp_pkg: cause codes, mstatus bit positions and FSM states for the trap/return sequencer
package core_ex_excp_pkg;
  localparam int CORE_XLEN = 32;
  localparam logic [3:0] CAUSE_IF_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK = 4'd3;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ECALL = 4'd11;
  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam logic [1:0] PRV_M = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_WRCSR, ST_REDIR} state_e;
  typedef struct packed {
    logic illegal;
    logic if_misalign;
    logic ecall;
    logic ebreak;
    logic st_misalign;
    logic ld_misalign;
  } exc_t;
  function automatic logic [3:0] exc_cause(exc_t e);
    return e.illegal ? CAUSE_ILLEGAL : e.if_misalign ? CAUSE_IF_MISALIGN :
           e.ecall ? CAUSE_ECALL : e.ebreak ? CAUSE_EBREAK :
           e.st_misalign ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
  endfunction
endpackage

// File: rtl/core_ex_excp_if.sv
// core_ex_excp_if: EX-side, CSR commit and IFU redirect signals of the trap/return sequencer
import core_ex_excp_pkg::*;
interface core_ex_excp_if #(parameter int XLEN = CORE_XLEN);
  logic ex_valid;
  logic ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic ex_illegal;
  logic ex_if_misalign;
  logic ex_ecall;
  logic ex_ebreak;
  logic ex_st_misalign;
  logic ex_ld_misalign;
  logic ex_mret;
  logic [XLEN-1:0] csr_mstatus_r;
  logic [XLEN-1:0] csr_mtvec_r;
  logic [XLEN-1:0] csr_mepc_r;
  logic cmt_mstatus_en;
  logic [XLEN-1:0] cmt_mstatus;
  logic cmt_mcause_en;
  logic [XLEN-1:0] cmt_mcause;
  logic cmt_mepc_en;
  logic [XLEN-1:0] cmt_mepc;
  logic flush;
  logic redir_valid;
  logic redir_ready;
  logic [XLEN-1:0] redir_pc;
  modport slave (
    input ex_valid, ex_pc, ex_illegal, ex_if_misalign, ex_ecall, ex_ebreak,
    input ex_st_misalign, ex_ld_misalign, ex_mret,
    input csr_mstatus_r, csr_mtvec_r, csr_mepc_r, redir_ready,
    output ex_ready, cmt_mstatus_en, cmt_mstatus, cmt_mcause_en, cmt_mcause,
    output cmt_mepc_en, cmt_mepc, flush, redir_valid, redir_pc
  );
  modport master (
    output ex_valid, ex_pc, ex_illegal, ex_if_misalign, ex_ecall, ex_ebreak,
    output ex_st_misalign, ex_ld_misalign, ex_mret,
    output csr_mstatus_r, csr_mtvec_r, csr_mepc_r, redir_ready,
    input ex_ready, cmt_mstatus_en, cmt_mstatus, cmt_mcause_en, cmt_mcause,
    input cmt_mepc_en, cmt_mepc, flush, redir_valid, redir_pc
  );
endinterface

// File: rtl/core_ex_excp.sv
// core_ex_excp: trap/MRET sequencer writing mepc/mcause/mstatus and redirecting fetch
module core_ex_excp
  import core_ex_excp_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input logic clk,
  input logic rst_n,
  core_ex_excp_if.slave io
);
  localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};
  state_e state;
  logic trap;
  logic [3:0] cause;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] mst;
  exc_t exc;
  logic any_exc;
  logic evt;
  logic wr;
  logic rd;
  assign exc = {io.ex_illegal, io.ex_if_misalign, io.ex_ecall, io.ex_ebreak,
                io.ex_st_misalign, io.ex_ld_misalign};
  assign any_exc = |exc;
  // an exception alongside MRET takes the trap path
  assign evt = io.ex_valid & (any_exc | io.ex_mret);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      trap <= 1'b0;
      cause <= '0;
      pc <= '0;
      tgt <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (evt) begin
            state <= ST_WRCSR;
            trap <= any_exc;
            cause <= exc_cause(exc);
            pc <= io.ex_pc & ALIGN;
            tgt <= (any_exc ? io.csr_mtvec_r : io.csr_mepc_r) & ALIGN;
          end
        ST_WRCSR: state <= ST_REDIR;
        default: if (io.redir_ready) state <= ST_IDLE;
      endcase
    end
  // mstatus is built from the CSR value live in the write cycle
  always_comb begin
    mst = io.csr_mstatus_r;
    mst[MSTATUS_MPIE] = trap ? io.csr_mstatus_r[MSTATUS_MIE] : 1'b1;
    mst[MSTATUS_MIE] = trap ? 1'b0 : io.csr_mstatus_r[MSTATUS_MPIE];
    mst[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_M;
  end
  assign wr = state == ST_WRCSR;
  assign rd = state == ST_REDIR;
  assign io.ex_ready = state == ST_IDLE;
  assign io.flush = state != ST_IDLE;
  assign io.redir_valid = rd;
  assign io.redir_pc = rd ? tgt : '0;
  assign io.cmt_mstatus_en = wr;
  assign io.cmt_mstatus = wr ? mst : '0;
  assign io.cmt_mepc_en = wr & trap;
  assign io.cmt_mepc = (wr & trap) ? pc : '0;
  assign io.cmt_mcause_en = wr & trap;
  assign io.cmt_mcause = (wr & trap) ? {{(XLEN-4){1'b0}}, cause} : '0;
endmodule

// File: tb/tb_core_ex_excp.sv
// tb_core_ex_excp: directed literal checks plus randomized traffic against a cycle-age model
module tb_core_ex_excp;
  import core_ex_excp_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  core_ex_excp_if #(.XLEN(32)) io ();
  core_ex_excp #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .io(io.slave));
  int checks = 0;
  int failures = 0;
  logic [5:0] exc_v;
  assign io.ex_illegal = exc_v[5];
  assign io.ex_if_misalign = exc_v[4];
  assign io.ex_ecall = exc_v[3];
  assign io.ex_ebreak = exc_v[2];
  assign io.ex_st_misalign = exc_v[1];
  assign io.ex_ld_misalign = exc_v[0];
  int age = 0;
  logic m_trap = 1'b0;
  logic [31:0] m_cause = '0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_tgt = '0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] cause_of(logic [5:0] e);
    int codes [6] = '{4, 6, 3, 11, 0, 2};
    for (int i = 5; i >= 0; i--) if (e[i]) return codes[i];
    return 0;
  endfunction
  function automatic logic [31:0] exp_mst(logic [31:0] m, logic t);
    return t ? ((m & ~32'h1888) | 32'h1800 | ((m & 32'h8) << 4))
             : ((m & ~32'h1888) | 32'h1880 | ((m & 32'h80) >> 4));
  endfunction
  // age: 0 idle, 1 CSR-write cycle, >=2 redirect pending
  always @(posedge clk or negedge rst_n)
    if (!rst_n) age <= 0;
    else if (age == 0) begin
      if (io.ex_valid && (exc_v != 0 || io.ex_mret)) begin
        age <= 1;
        m_trap <= exc_v != 0;
        m_cause <= cause_of(exc_v);
        m_pc <= io.ex_pc & ~32'h3;
        m_tgt <= (exc_v != 0 ? io.csr_mtvec_r : io.csr_mepc_r) & ~32'h3;
      end
    end else if (age >= 2 && io.redir_ready) age <= 0;
    else age <= age + 1;
  always @(negedge clk) begin
    chk("ex_ready", io.ex_ready, age == 0);
    chk("flush", io.flush, age != 0);
    chk("redir_valid", io.redir_valid, age >= 2);
    if (age >= 2) chk("redir_pc", io.redir_pc, m_tgt);
    chk("mstatus_en", io.cmt_mstatus_en, age == 1);
    chk("mepc_en", io.cmt_mepc_en, age == 1 && m_trap);
    chk("mcause_en", io.cmt_mcause_en, age == 1 && m_trap);
    if (age == 1) begin
      chk("mstatus", io.cmt_mstatus, exp_mst(io.csr_mstatus_r, m_trap));
      if (m_trap) begin
        chk("mepc", io.cmt_mepc, m_pc);
        chk("mcause", io.cmt_mcause, m_cause);
      end
    end
  end
  task automatic drive_idle();
    io.ex_valid = 1'b0;
    exc_v = '0;
    io.ex_mret = 1'b0;
  endtask
  task automatic issue(logic [31:0] pc, logic [5:0] e, logic mret);
    io.ex_valid = 1'b1;
    io.ex_pc = pc;
    exc_v = e;
    io.ex_mret = mret;
    @(posedge clk);
    #1;
    drive_idle();
  endtask
  task automatic wait_idle();
    int n = 0;
    @(posedge clk);
    #1;
    while (!io.ex_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_timeout", io.ex_ready, 1);
  endtask
  initial begin
    drive_idle();
    io.ex_pc = '0;
    io.redir_ready = 1'b0;
    io.csr_mstatus_r = '0;
    io.csr_mtvec_r = '0;
    io.csr_mepc_r = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", io.ex_ready, 1);
    chk("rst_redir_valid", io.redir_valid, 0);
    chk("rst_redir_pc", io.redir_pc, 0);
    chk("rst_cmt_mstatus", io.cmt_mstatus, 0);
    chk("rst_flush", io.flush, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    io.csr_mtvec_r = 32'h8000_0201;
    io.csr_mstatus_r = 32'h0000_0008;
    issue(32'h8000_0104, 6'b001000, 1'b0);
    @(negedge clk);
    chk("ecall_mepc_en", io.cmt_mepc_en, 1);
    chk("ecall_mepc", io.cmt_mepc, 32'h8000_0104);
    chk("ecall_mcause", io.cmt_mcause, 11);
    chk("ecall_mstatus", io.cmt_mstatus, 32'h0000_1880);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_redir_valid", io.redir_valid, 1);
      chk("hold_redir_pc", io.redir_pc, 32'h8000_0200);
      chk("hold_flush", io.flush, 1);
      chk("hold_ex_ready", io.ex_ready, 0);
    end
    @(posedge clk);
    #1 io.redir_ready = 1'b1;
    @(posedge clk);
    #1 io.redir_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_redir", io.ex_ready, 1);
    @(posedge clk);
    #1;
    io.csr_mepc_r = 32'h8000_0108;
    io.csr_mstatus_r = 32'h0000_1880;
    io.redir_ready = 1'b1;
    issue(32'h8000_0200, 6'b000000, 1'b1);
    @(negedge clk);
    chk("mret_mstatus_en", io.cmt_mstatus_en, 1);
    chk("mret_mstatus", io.cmt_mstatus, 32'h0000_1888);
    chk("mret_mepc_en", io.cmt_mepc_en, 0);
    chk("mret_mcause_en", io.cmt_mcause_en, 0);
    @(negedge clk);
    chk("mret_redir_pc", io.redir_pc, 32'h8000_0108);
    wait_idle();
    io.csr_mtvec_r = 32'h0000_1000;
    issue(32'h0000_0040, 6'b100101, 1'b0);
    @(negedge clk);
    chk("prio_illegal", io.cmt_mcause, 2);
    wait_idle();
    issue(32'h0000_0044, 6'b000100, 1'b1);
    @(negedge clk);
    chk("mret_ebreak_cause", io.cmt_mcause, 3);
    chk("mret_ebreak_mepc_en", io.cmt_mepc_en, 1);
    wait_idle();
    io.ex_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("plain_ready", io.ex_ready, 1);
      chk("plain_flush", io.flush, 0);
      chk("plain_strobe", io.cmt_mstatus_en, 0);
    end
    @(posedge clk);
    #1 drive_idle();
    io.csr_mstatus_r = 32'h0000_0008;
    issue(32'h0000_0080, 6'b001000, 1'b0);
    #2 chk("pre_rst_strobe", io.cmt_mepc_en, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_mepc_en", io.cmt_mepc_en, 0);
    chk("rst_async_mstatus_en", io.cmt_mstatus_en, 0);
    chk("rst_async_ready", io.ex_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_mstatus_en", io.cmt_mstatus_en, 0);
      chk("post_rst_ready", io.ex_ready, 1);
    end
    @(posedge clk);
    #1;
    repeat (400) begin
      io.ex_valid = 1'($urandom_range(0, 1));
      for (int b = 0; b < 6; b++) exc_v[b] = $urandom_range(0, 7) == 0;
      io.ex_mret = $urandom_range(0, 5) == 0;
      io.ex_pc = $urandom;
      io.csr_mstatus_r = $urandom;
      io.csr_mtvec_r = $urandom;
      io.csr_mepc_r = $urandom;
      io.redir_ready = $urandom_range(0, 2) != 0;
      @(posedge clk);
      #1;
    end
    drive_idle();
    io.redir_ready = 1'b1;
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
